ysyx_040750_intr_ctrl: RTL and testbench

Parametrised machine-mode interrupt controller. It supersedes the single-source, purely combinational timer-interrupt gate. It arbitrates NSRC level interrupt sources (timer, software, external, ...) against committed CSR state and against in-flight CSR writes and traps in NSTAGE pipeline stages. It then runs a request/ack/commit handshake with the ID-stage injector, with a programmable re-arm gap after each taken interrupt. It sits between the CLINT/CSR file and the ID stage.

---
 rtl/ysyx_040750_intr_ctrl.sv | 142 ++++++++++++++
 tb/tb_ysyx_040750_intr_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_040750_intr_ctrl.sv
// Machine-mode interrupt controller: arbitrates level sources against committed and
// in-flight CSR state, then runs a request/ack/commit handshake with the ID injector.
module ysyx_040750_intr_ctrl #(
  parameter int unsigned          NSRC      = 3,
  parameter int unsigned          NSTAGE    = 3,
  parameter logic [4*NSRC-1:0]    CAUSE_MAP = 12'hB37,
  parameter int unsigned          GAP_CYC   = 2,
  parameter int unsigned          GAPW      = 4
) (
  input  logic                       I_sys_clk,
  input  logic                       I_rst,
  input  logic [NSRC-1:0]            I_irq_pend,
  input  logic                       I_csr_mstatus_mie,
  input  logic [NSRC-1:0]            I_csr_mie,
  input  logic [NSTAGE-1:0]          I_stage_trap,
  input  logic [NSTAGE-1:0]          I_stage_csr_wen,
  input  logic [NSTAGE*12-1:0]       I_stage_csr_addr,
  input  logic [NSTAGE*(NSRC+1)-1:0] I_stage_csr_data,
  input  logic                       I_inject_ack,
  input  logic                       I_WB_intr,
  input  logic                       I_flush_abort,
  output logic                       O_intr_req,
  output logic [3:0]                 O_intr_cause,
  output logic                       O_busy
);

  localparam int unsigned DW = NSRC + 1;
  localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [SW-1:0]   src_q, src_d;
  logic [3:0]      cause_q, cause_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;

  logic [NSRC-1:0] stage_mask;
  logic            blk;
  logic [NSRC-1:0] eligible;
  logic [SW-1:0]   sel_idx;
  logic [3:0]      sel_cause;

  // In-flight CSR writes and traps override the committed enables.
  always_comb begin
    stage_mask = '1;
    blk        = |I_stage_trap;
    for (int k = 0; k < NSTAGE; k++) begin
      if (I_stage_csr_wen[k]) begin
        if (I_stage_csr_addr[12*k +: 12] == CSR_MIE)
          stage_mask = stage_mask & I_stage_csr_data[DW*k+1 +: NSRC];
        if (I_stage_csr_addr[12*k +: 12] == CSR_MSTATUS && !I_stage_csr_data[DW*k])
          blk = 1'b1;
      end
    end
    eligible = blk ? '0 : (I_irq_pend & I_csr_mie & {NSRC{I_csr_mstatus_mie}} & stage_mask);
  end

  // Highest set index wins.
  always_comb begin
    sel_idx   = '0;
    sel_cause = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (eligible[i]) begin
        sel_idx   = SW'(i);
        sel_cause = CAUSE_MAP[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    src_d   = src_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible && gap_q == '0) begin
          state_d = S_REQ;
          src_d   = sel_idx;
          cause_d = sel_cause;
        end
      end
      S_REQ: begin
        if (I_inject_ack)           state_d = S_WAIT;
        else if (!eligible[src_q])  state_d = S_IDLE;
      end
      S_WAIT: begin
        // Commit takes priority over a simultaneous abort.
        if (I_WB_intr) begin
          if (GAP_CYC == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAPW'(GAP_CYC);
          end
        end else if (I_flush_abort) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        gap_d = gap_q - GAPW'(1);
        if (gap_q <= GAPW'(1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase
    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge I_sys_clk) begin
    if (I_rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      src_q   <= '0;
      cause_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      src_q   <= src_d;
      cause_q <= cause_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
    end
  end

  assign O_intr_req   = req_q;
  assign O_intr_cause = cause_q;
  assign O_busy       = busy_q;

endmodule

// File: tb/tb_ysyx_040750_intr_ctrl.sv
// Scoreboard bench: stimulus queues the expected cause and cycle of each request,
// a negedge monitor matches every rising O_intr_req against the queue.
module tb_ysyx_040750_intr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pend, mie, trap, wen;
  logic        mstatus;
  logic [35:0] addr;
  logic [11:0] data;
  logic        ack, wb, flush;
  logic        req;
  logic [3:0]  cause;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int cause;
    int at;
  } exp_t;
  exp_t sb[$];

  ysyx_040750_intr_ctrl dut (
    .I_sys_clk         (clk),
    .I_rst             (rst),
    .I_irq_pend        (pend),
    .I_csr_mstatus_mie (mstatus),
    .I_csr_mie         (mie),
    .I_stage_trap      (trap),
    .I_stage_csr_wen   (wen),
    .I_stage_csr_addr  (addr),
    .I_stage_csr_data  (data),
    .I_inject_ack      (ack),
    .I_WB_intr         (wb),
    .I_flush_abort     (flush),
    .O_intr_req        (req),
    .O_intr_cause      (cause),
    .O_busy            (busy)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input int c);
    exp_t e;
    e.cause = c;
    e.at    = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic chk_quiet(input string name, input int exp_busy);
    chk({name, "_req"}, int'(req), 0);
    chk({name, "_busy"}, int'(busy), exp_busy);
  endtask

  // Monitor: every new request must match the head of the scoreboard.
  initial begin
    logic req_prev;
    exp_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (req && !req_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("req_cause", int'(cause), e.cause);
          chk("req_cycle", cyc, e.at);
        end
      end
      req_prev = req;
    end
  end

  initial begin
    rst = 1'b1; pend = '0; mie = '0; mstatus = 1'b0; trap = '0; wen = '0;
    addr = '0; data = '0; ack = 1'b0; wb = 1'b0; flush = 1'b0;
    tick(2);
    chk("rst_req", int'(req), 0);
    chk("rst_cause", int'(cause), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // MTI request, ack, commit, gap, re-request
    pend = 3'b001; mie = 3'b111; mstatus = 1'b1;
    expect_req(7);
    tick(1);
    chk("req_busy", int'(busy), 1);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk_quiet("wait", 1);
    tick(1);
    chk_quiet("wait_hold", 1);
    wb = 1'b1; tick(1); wb = 1'b0;
    chk_quiet("gap0", 1);
    tick(1);
    chk_quiet("gap1", 1);
    tick(1);
    chk_quiet("gap_done", 0);
    expect_req(7);
    tick(1);

    // Flush abort returns to IDLE without gap; then MEI+MTI, withdraw
    ack = 1'b1; tick(1); ack = 1'b0;
    flush = 1'b1; tick(1); flush = 1'b0;
    chk_quiet("flush_idle", 0);
    pend = 3'b101;
    expect_req(11);
    tick(1);
    chk("mei_cause_hold", int'(cause), 11);
    pend = 3'b001; tick(1);
    chk_quiet("withdraw", 0);
    expect_req(7);
    tick(1);

    // In-flight MSTATUS write clearing MIE blocks through EX, MEM and WB
    ack = 1'b1; tick(1); ack = 1'b0;
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wen = 3'(1 << k);
      addr = '0; addr[12*k +: 12] = 12'h300;
      data = '0;
      tick(1);
      flush = 1'b0;
      if (k > 0) chk_quiet("mstatus_blk", 0);
    end
    tick(1);
    chk_quiet("mstatus_blk_wb", 0);
    // MEM stage MIE write dropping mie[0] masks MTI
    wen = 3'b010; addr = '0; addr[23:12] = 12'h304; data = '0; data[7:4] = 4'b1101;
    tick(1);
    chk_quiet("mie_mask", 0);
    wen = '0; addr = '0; data = '0;
    expect_req(7);
    tick(1);

    // MEM trap suppression, then ack and drop in same cycle
    ack = 1'b1; tick(1); ack = 1'b0;
    flush = 1'b1; trap = 3'b010; tick(1); flush = 1'b0;
    tick(1);
    chk_quiet("trap_blk", 0);
    trap = '0;
    expect_req(7);
    tick(1);
    ack = 1'b1; pend = 3'b000; tick(1); ack = 1'b0;
    chk_quiet("ack_wins", 1);
    wb = 1'b1; flush = 1'b1; tick(1); wb = 1'b0; flush = 1'b0;
    chk_quiet("commit_wins", 1);
    tick(1);
    chk_quiet("commit_gap", 1);
    tick(1);
    chk_quiet("commit_idle", 0);

    // Stray ack in IDLE, then reset mid-request
    ack = 1'b1; tick(1); ack = 1'b0;
    chk_quiet("stray_ack", 0);
    pend = 3'b100;
    expect_req(11);
    tick(1);
    rst = 1'b1; pend = '0; tick(1);
    chk("rst_mid_req", int'(req), 0);
    chk("rst_mid_cause", int'(cause), 0);
    chk("rst_mid_busy", int'(busy), 0);
    rst = 1'b0;
    tick(3);
    chk_quiet("post_rst", 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
